// File: rtl/wb_timer16.sv
// wb_timer16: 16-bit WISHBONE timer/counter with prescaler, OVF/CMP flags, CTC and TEMP-latched 16-bit access.
// Define WB_TIMER16_PWM_EN to build the registered PWM output; otherwise pwm_o is tied low.
module wb_timer16 #(
  parameter logic [7:0] BASE_ADR = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       irq_o,
  input  logic       irq_ack_i,
  output logic       pwm_o
);
  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CNTL   = 3'd2;
  localparam logic [2:0] A_CNTH   = 3'd3;
  localparam logic [2:0] A_CMPL   = 3'd4;
  localparam logic [2:0] A_CMPH   = 3'd5;

  logic        ack_q, ack_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d, cmpf_q, cmpf_d;
  logic [15:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic [7:0]  temp_q, temp_d, psc_q, psc_d;

  logic       sel, wr, rd, tick, match;
  logic       ovf_set, cmp_set, ovf_clr, cmp_clr, irq_cmp, irq_ovf;
  logic [2:0] off;
  logic [7:0] div_m1, rdata;

  assign off   = wb_adr_i[2:0];
  assign sel   = wb_stb_i & (wb_adr_i[7:3] == BASE_ADR[7:3]);
  assign ack_d = sel & ~ack_q;
  // Side effects are taken on the edge that closes the ack cycle, so each strobe acts once.
  assign wr    = ack_q & sel & wb_we_i;
  assign rd    = ack_q & sel & ~wb_we_i;

  always_comb begin
    unique case (ctrl_q[2:1])
      2'b00:   div_m1 = 8'd0;
      2'b01:   div_m1 = 8'd7;
      2'b10:   div_m1 = 8'd63;
      default: div_m1 = 8'd255;
    endcase
  end

  assign tick  = ctrl_q[0] & (psc_q == div_m1);
  assign match = (cnt_q == cmp_q);

  always_comb begin
    psc_d = psc_q + 8'd1;
    if ((wr && off == A_CTRL) || !ctrl_q[0] || tick) psc_d = 8'd0;
  end

  // A CNT_L write overrides the tick of the same cycle, including its flags.
  always_comb begin
    cnt_d   = cnt_q;
    cmp_set = 1'b0;
    ovf_set = 1'b0;
    if (wr && off == A_CNTL) begin
      cnt_d = {temp_q, wb_dat_i};
    end else if (tick) begin
      cmp_set = match;
      ovf_set = &cnt_q;
      cnt_d   = (ctrl_q[3] && match) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  assign irq_cmp = cmpf_q & ctrl_q[5];
  assign irq_ovf = ovf_q & ctrl_q[4];
  assign cmp_clr = (wr && off == A_STATUS && wb_dat_i[1]) | (irq_ack_i & irq_cmp);
  assign ovf_clr = (wr && off == A_STATUS && wb_dat_i[0]) | (irq_ack_i & ~irq_cmp & irq_ovf);
  assign cmpf_d  = cmp_set | (cmpf_q & ~cmp_clr);
  assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);

  always_comb begin
    ctrl_d = ctrl_q;
    cmp_d  = cmp_q;
    temp_d = temp_q;
    if (wr && off == A_CTRL) ctrl_d = wb_dat_i[5:0];
    if (wr && off == A_CMPL) cmp_d = {temp_q, wb_dat_i};
    if (wr && (off == A_CNTH || off == A_CMPH)) temp_d = wb_dat_i;
    if (rd && off == A_CNTL) temp_d = cnt_q[15:8];
  end

  always_comb begin
    unique case (off)
      A_CTRL:   rdata = {2'b00, ctrl_q};
      A_STATUS: rdata = {6'd0, cmpf_q, ovf_q};
      A_CNTL:   rdata = cnt_q[7:0];
      A_CNTH:   rdata = temp_q;
      A_CMPL:   rdata = cmp_q[7:0];
      A_CMPH:   rdata = cmp_q[15:8];
      default:  rdata = 8'd0;
    endcase
  end

  assign wb_dat_o = rd ? rdata : 8'd0;
  assign wb_ack_o = ack_q;
  assign irq_o    = irq_cmp | irq_ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q  <= 1'b0;
      ctrl_q <= 6'd0;
      ovf_q  <= 1'b0;
      cmpf_q <= 1'b0;
      cnt_q  <= 16'd0;
      cmp_q  <= 16'd0;
      temp_q <= 8'd0;
      psc_q  <= 8'd0;
    end else begin
      ack_q  <= ack_d;
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
      cmpf_q <= cmpf_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      temp_q <= temp_d;
      psc_q  <= psc_d;
    end
  end

`ifdef WB_TIMER16_PWM_EN
  logic pwm_q, pwm_d;
  assign pwm_d = (cnt_q < cmp_q) & ctrl_q[0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_q <= 1'b0;
    else         pwm_q <= pwm_d;
  end
  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_timer16.sv
// Self-checking bench for wb_timer16: register table, hand-timed corner sequences and random traffic vs a reference model.
module tb_wb_timer16;
  localparam logic [7:0] BASE = 8'h20;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] wb_adr_i = 8'h00;
  logic [7:0] wb_dat_i = 8'h00;
  logic [7:0] wb_dat_o;
  logic       wb_stb_i = 1'b0;
  logic       wb_we_i = 1'b0;
  logic       wb_ack_o;
  logic       irq_o;
  logic       irq_ack_i = 1'b0;
  logic       pwm_o;

  wb_timer16 #(.BASE_ADR(BASE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .irq_o(irq_o), .irq_ack_i(irq_ack_i), .pwm_o(pwm_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  logic obs_ack, obs_irq, obs_pwm;
  logic [7:0] obs_dat;

  // Reference model state: what the timer should hold right now.
  int          m_psc;
  logic        m_ack, m_ovf, m_cmpf, m_pwm;
  logic [5:0]  m_ctrl;
  logic [15:0] m_cnt, m_cmp;
  logic [7:0]  m_temp;

  typedef struct {
    bit         we;
    logic [7:0] adr;
    logic [7:0] dat;
    logic [7:0] exp;
    bit         ack;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int divisor(input logic [1:0] ps);
    case (ps)
      2'd0:    return 1;
      2'd1:    return 8;
      2'd2:    return 64;
      default: return 256;
    endcase
  endfunction

  function automatic bit m_sel();
    return wb_stb_i && (wb_adr_i[7:3] == BASE[7:3]);
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] off);
    case (off)
      3'd0:    return {2'b00, m_ctrl};
      3'd1:    return {6'd0, m_cmpf, m_ovf};
      3'd2:    return m_cnt[7:0];
      3'd3:    return m_temp;
      3'd4:    return m_cmp[7:0];
      3'd5:    return m_cmp[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_psc = 0; m_ack = 0; m_ovf = 0; m_cmpf = 0; m_pwm = 0;
    m_ctrl = '0; m_cnt = '0; m_cmp = '0; m_temp = '0;
  endtask

  task automatic model_edge();
    bit fw, fr, tick, set_o, set_c, clr_o, clr_c;
    logic [2:0] off;
    logic [15:0] nxt;
    off = wb_adr_i[2:0];
    fw = m_ack && m_sel() && wb_we_i;
    fr = m_ack && m_sel() && !wb_we_i;
    tick = m_ctrl[0] && ((m_psc + 1) % divisor(m_ctrl[2:1]) == 0);
    set_o = 0; set_c = 0; nxt = m_cnt;
    if (fw && off == 3'd2) nxt = {m_temp, wb_dat_i};
    else if (tick) begin
      set_c = (m_cnt == m_cmp);
      set_o = (m_cnt == 16'hFFFF);
      if (m_ctrl[3] && m_cnt == m_cmp) nxt = 16'd0;
      else nxt = 16'((32'(m_cnt) + 1) % 65536);
    end
    clr_c = (fw && off == 3'd1 && wb_dat_i[1]) || (irq_ack_i && m_cmpf && m_ctrl[5]);
    clr_o = (fw && off == 3'd1 && wb_dat_i[0]) ||
            (irq_ack_i && !(m_cmpf && m_ctrl[5]) && m_ovf && m_ctrl[4]);
`ifdef WB_TIMER16_PWM_EN
    m_pwm = (m_cnt < m_cmp) && m_ctrl[0];
`endif
    if (!m_ctrl[0] || (fw && off == 3'd0)) m_psc = 0;
    else m_psc = (m_psc + 1) % divisor(m_ctrl[2:1]);
    if (fw && off == 3'd4) m_cmp = {m_temp, wb_dat_i};
    if (fr && off == 3'd2) m_temp = m_cnt[15:8];
    else if (fw && (off == 3'd3 || off == 3'd5)) m_temp = wb_dat_i;
    if (fw && off == 3'd0) m_ctrl = wb_dat_i[5:0];
    m_cnt = nxt;
    m_cmpf = set_c || (m_cmpf && !clr_c);
    m_ovf = set_o || (m_ovf && !clr_o);
    m_ack = m_sel() && !m_ack;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model on the edge.
  task automatic step();
    logic [7:0] ed;
    @(negedge clk_i);
    obs_ack = wb_ack_o; obs_dat = wb_dat_o; obs_irq = irq_o; obs_pwm = pwm_o;
    ed = (m_ack && m_sel() && !wb_we_i) ? m_read(wb_adr_i[2:0]) : 8'h00;
    chk("ack", wb_ack_o, m_ack);
    chk("dat_o", wb_dat_o, ed);
    chk("irq", irq_o, (m_ovf && m_ctrl[4]) || (m_cmpf && m_ctrl[5]));
    chk("pwm", pwm_o, m_pwm);
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic bus(input bit we, input logic [7:0] adr, input logic [7:0] d,
                     output logic [7:0] rd, output bit ok);
    wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = d;
    ok = 0; rd = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_ack) begin ok = 1; rd = obs_dat; break; end
    end
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] rd; bit ok;
    bus(1'b1, BASE + 8'(off), d, rd, ok);
    chk($sformatf("wr%0d_ack", off), ok, 1);
  endtask

  task automatic rdr(input logic [2:0] off, output logic [7:0] rd);
    bit ok;
    bus(1'b0, BASE + 8'(off), 8'h00, rd, ok);
    chk($sformatf("rd%0d_ack", off), ok, 1);
  endtask

  task automatic wait_irq(input string nm, input int exp_idx);
    int n;
    n = -1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (obs_irq) begin n = i; break; end
    end
    chk(nm, n, exp_idx);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; wb_stb_i = 0; wb_we_i = 0; irq_ack_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_pwm", pwm_o, 0);
    rst_ni = 1'b1;
  endtask

  function automatic vec_t mk(input bit we, input logic [7:0] adr, input logic [7:0] d,
                              input logic [7:0] e, input bit a);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = d; v.exp = e; v.ack = a;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    bit ok;
    int npwm;

    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, BASE + 8'(i), 8'h00, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd8, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, BASE + 8'd0, 8'h3E, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd0, 8'h00, 8'h3E, 1));
    tbl.push_back(mk(1, BASE + 8'd0, 8'hFE, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd0, 8'h00, 8'h3E, 1));
    tbl.push_back(mk(1, BASE + 8'd3, 8'hAB, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd3, 8'h00, 8'hAB, 1));
    tbl.push_back(mk(1, BASE + 8'd2, 8'hCD, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd2, 8'h00, 8'hCD, 1));
    tbl.push_back(mk(0, BASE + 8'd3, 8'h00, 8'hAB, 1));
    tbl.push_back(mk(1, BASE + 8'd5, 8'h12, 8'h00, 1));
    tbl.push_back(mk(1, BASE + 8'd4, 8'h34, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd4, 8'h00, 8'h34, 1));
    tbl.push_back(mk(0, BASE + 8'd5, 8'h00, 8'h12, 1));
    tbl.push_back(mk(0, BASE + 8'd3, 8'h00, 8'h12, 1));
    tbl.push_back(mk(1, BASE + 8'd6, 8'hFF, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd6, 8'h00, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd7, 8'h00, 8'h00, 1));
    tbl.push_back(mk(1, BASE + 8'd1, 8'hFF, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd1, 8'h00, 8'h00, 1));
    tbl.push_back(mk(1, BASE + 8'd0, 8'h00, 8'h00, 1));
    tbl.push_back(mk(0, BASE + 8'd0, 8'h00, 8'h00, 1));

    do_reset();
    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].dat, rd, ok);
      chk($sformatf("tbl%0d_ack", i), ok, tbl[i].ack);
      if (tbl[i].ack && !tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
    end

    // CTC at CMP=4, /1: counts 0..4, flag and irq appear the cycle after the CNT=4 tick.
    wr(3, 8'h00); wr(2, 8'h00); wr(5, 8'h00); wr(4, 8'h04); wr(0, 8'h29);
    wait_irq("ctc_irq_cycle", 5);
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    step();
    chk("irq_after_ack", obs_irq, 0);
    wr(0, 8'h00); wr(1, 8'h03);

    // Overflow at /8 from 0xFFFE: two ticks, 16 clocks.
    wr(3, 8'hFF); wr(2, 8'hFE); wr(0, 8'h13);
    wait_irq("ovf_irq_cycle", 16);
    wr(1, 8'h01);
    rdr(1, rd);
    chk("ovf_w1c", rd[0], 0);

    // Atomic read of a running count across the 0x12FF -> 0x1300 carry.
    wr(0, 8'h00); wr(3, 8'h12); wr(2, 8'hF0); wr(0, 8'h01);
    repeat (14) step();
    rdr(2, rd);
    chk("atomic_lo", rd, 8'hFF);
    rdr(3, rd);
    chk("atomic_hi", rd, 8'h12);

    // W1C of OVF landing on the edge of a fresh overflow.
    wr(0, 8'h00); wr(5, 8'h80); wr(4, 8'h00); wr(3, 8'hFF); wr(2, 8'hF0); wr(0, 8'h11);
    wait_irq("ovf2_irq_cycle", 16);
    wr(3, 8'hFF); wr(2, 8'hFE); wr(1, 8'h01);
    rdr(1, rd);
    chk("ovf_set_wins", rd[0], 1);
    chk("ovf_irq_kept", obs_irq, 1);

    // CNT_L write on a tick edge (/1): lands exactly, then one increment before the read ack.
    wr(3, 8'h00); wr(2, 8'h55);
    rdr(2, rd);
    chk("cntl_write_wins", rd, 8'h56);

    // PWM with CTC period 8 (CMP=7): high while CNT<CMP.
    wr(0, 8'h00); wr(3, 8'h00); wr(2, 8'h00); wr(5, 8'h00); wr(4, 8'h07); wr(0, 8'h09);
    repeat (10) step();
    npwm = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (obs_pwm) npwm++;
    end
`ifdef WB_TIMER16_PWM_EN
    chk("pwm_high_count", npwm, 28);
`else
    chk("pwm_high_count", npwm, 0);
`endif
    wr(0, 8'h00);

    // Reset while ack is high: ack drops without waiting for a clock.
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = BASE;
    step();
    chk("ack_before_rst", wb_ack_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("ack_async_drop", wb_ack_o, 0);
    model_reset();
    wb_stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        repeat ($urandom_range(1, 3)) step();
      end else if (r == 1) begin
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
      end else begin
        logic [7:0] a;
        a = BASE + 8'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) a = a + 8'd8;
        bus(1'($urandom_range(0, 1)), a, 8'($urandom), rd, ok);
        chk("rand_ack", ok, (a[7:3] == BASE[7:3]) ? 1 : 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
